// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings, branch condition codes and the NZVC flag layout.
package alu_pkg;
    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [3:0] {
        EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a B.cond condition code against the NZVC flags.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  nzvc_t      flags,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b1;
        case (cond_e'(cond))
            EQ:      cond_true = flags.z;
            NE:      cond_true = ~flags.z;
            HS:      cond_true = flags.c;
            LO:      cond_true = ~flags.c;
            MI:      cond_true = flags.n;
            PL:      cond_true = ~flags.n;
            VS:      cond_true = flags.v;
            VC:      cond_true = ~flags.v;
            HI:      cond_true = flags.c & ~flags.z;
            LS:      cond_true = ~flags.c | flags.z;
            GE:      cond_true = flags.n == flags.v;
            LT:      cond_true = flags.n != flags.v;
            GT:      cond_true = ~flags.z & (flags.n == flags.v);
            LE:      cond_true = flags.z | (flags.n != flags.v);
            default: cond_true = 1'b1;
        endcase
    end
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: NZVC flag register, branch resolution and EX/MEM pipeline register.
module ex_flag_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic              set_flags,
    input  logic              is_bcond,
    input  logic              is_cbz,
    input  logic              is_cbnz,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        flags_q,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic              mem_br_taken,
    output logic [ADDR_W-1:0] mem_br_target
);
    nzvc_t alu_nzvc;
    logic  cond_true, taken, commit;

    assign alu_nzvc = nzvc_t'(alu_flags);
    assign commit   = ex_valid & ~stall & ~flush;
    // CBZ/CBNZ use the live ALU zero (PASS_B), B.cond uses the architectural flags
    assign taken    = (is_bcond & cond_true) | (is_cbz & alu_nzvc.z) | (is_cbnz & ~alu_nzvc.z);

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (nzvc_t'(flags_q)),
        .cond_true (cond_true)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= 4'b0000;
        else if (commit & set_flags)
            flags_q <= alu_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_br_taken  <= 1'b0;
            mem_br_target <= '0;
        end else if (!stall) begin
            mem_valid     <= ex_valid & ~flush;
            mem_result    <= alu_result;
            mem_br_taken  <= taken & ex_valid & ~flush;
            mem_br_target <= br_target;
        end
    end
endmodule
